ascon_op_ctrl: RTL and testbench
================================

Name: ascon_op_ctrl

Overview:
Host-side controller and sequencer for the Ascon core. It holds the key, plaintext/ciphertext, associated-data and nonce registers, and serializes the nonce into core state S_3/S_4 through the state-shift port. It launches the operation with a one-cycle operation_ready pulse, captures core writebacks, and reports done, busy and error to the host (SPI/register front end).

Parameters:
TIMEOUT_CYCLES, 255, maximum number of RUN-state cycles before abort (1..1023)
TO_W, 10, width of the watchdog counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
host_wr_en  in  1  host byte write strobe
host_wr_addr  in  6  [5:4] register (0=key, 1=text, 2=AD/tag, 3=nonce); [3:0] byte index, 0=LSB
host_wr_data  in  8  write byte
host_rd_addr  in  6  read address, same map
host_rd_data  out  8  combinational read of the addressed byte
cmd_valid  in  1  command request
cmd_mode  in  3  0=idle, 1=encrypt, 2=decrypt, 3=hash, 4=xof, 5=cxof
cmd_ready  out  1  high only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
error  out  1  sticky; cleared by the next accepted valid command
reg0_128b, reg1_128b, reg2_128b  out  128 each  register file to core (key, text, AD/tag)
operation_mode  out  3  latched cmd_mode
operation_ready  out  1  one-cycle start pulse
state_shift_en  out  1  shift enable to core
state_shift_sel  out  3  3=S_3, 4=S_4
state_shift_lsb  out  1  serial bit; the core does S <= {S[62:0], lsb}
reg_128b_wrback_en  in  1  core writeback strobe
reg_128b_wrback_sel  in  2  0=reg0, 1=reg1, 2=reg2
reg_128b_wrback_val  in  128  writeback data

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - FSM goes to IDLE; all four 128-bit registers clear to 0.
  - Outputs: cmd_ready=1; busy=0, done=0, error=0, operation_ready=0, operation_mode=0, state_shift_en=0, state_shift_sel=0, state_shift_lsb=0.
- FSM states: IDLE, SHIFT_S3, SHIFT_S4, START, RUN.
- Command acceptance: in IDLE, the command is accepted on cmd_valid && cmd_ready.
  - Modes 1/2: go to SHIFT_S3.
  - Modes 3/4/5: go to START.
  - Modes 0/6/7: rejected. error is set, the FSM stays in IDLE and done does not pulse.
  - operation_mode latches on acceptance and holds until the FSM returns to IDLE.
- SHIFT_S3: 64 cycles, nonce bits 127 down to 64, MSB first, state_shift_sel=3. SHIFT_S4: 64 cycles, bits 63..0, sel=4.
  - state_shift_en is high for exactly 128 consecutive cycles.
  - A 7-bit counter indexes the bit; the transition happens on count 63 and count 127.
- START: operation_ready=1 for exactly one cycle, then RUN.
  - For a command accepted at cycle T: the pulse is at T+129 for encrypt/decrypt and at T+1 for hash modes.
- RUN: the watchdog counts from 0.
  - A writeback with sel=2 completes the operation: done pulses in the next cycle and the FSM enters IDLE at the same time.
  - If the watchdog reaches TIMEOUT_CYCLES first, error is set and the FSM goes to IDLE with no done pulse.
- Writeback capture: whenever reg_128b_wrback_en=1, in any state, the selected register loads reg_128b_wrback_val. sel=3 is ignored.
- Host writes are ignored while busy=1; error is not set. In IDLE, a host write and a core writeback to the same register in the same cycle: the core wins.
- host_rd_data is always readable, including while busy.
- A writeback that arrives in the same cycle as a timeout is still captured; timeout takes precedence for done/error.

Optional Feature:
ASCON_CTRL_KEY_ZEROIZE_EN
- Defined: in the cycle in which done pulses, or an abort occurs, reg0 (key) clears to 0. The host must rewrite the key before the next command.
- Not defined: the key is retained across operations.

Decomposition:
- Package ascon_ctrl_pkg holds:
  - mode codes 0..5
  - writeback-select codes REG0/1/2_WRBACK_SEL = 0/1/2
  - shift-select codes S3=3, S4=4
  - FSM state encoding
  - register address map constants
- One sub-module is natural: ascon_nonce_shifter. It takes start and the 128-bit nonce and produces shift_en, sel, lsb and a last flag, using the 7-bit counter.

Test Plan:
- Reset mid-SHIFT_S4 (rst high at shift cycle 90): all outputs return to their reset values at once; all registers read 0; cmd_ready=1.
- Nonce 0x000102...0F, encrypt accepted at T: state_shift_en is high at T+1..T+128; lsb sequence equals nonce bits 127→0; sel=3 for 64 cycles then sel=4; operation_ready is a single pulse at T+129.
- Hash command at T: no shifting, operation_ready at T+1; core writeback sel=1 then sel=2 (0xDEAD...BEEF): reg1 and reg2 are updated, and done is a single pulse one cycle after the sel=2 writeback.
- cmd_mode=7: error=1, busy stays 0, no operation_ready, no done. A subsequent valid encrypt clears error.
- TIMEOUT_CYCLES=20 and the core never writes back: error=1 and the FSM returns to IDLE 20 cycles into RUN; done stays 0.
- Host writes 0xAA to byte 0 of reg1 while busy: reg1 is unchanged. In IDLE, a same-cycle host write and core writeback to reg2: reg2 holds the core value.

Source files
------------

// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the Ascon host-side operation controller:
// mode codes, writeback/shift select codes, FSM encoding, register map
// and small helper functions.
package ascon_ctrl_pkg;

    // Operation modes carried on cmd_mode / operation_mode
    localparam logic [2:0] MODE_IDLE = 3'd0;
    localparam logic [2:0] MODE_ENC  = 3'd1;
    localparam logic [2:0] MODE_DEC  = 3'd2;
    localparam logic [2:0] MODE_HASH = 3'd3;
    localparam logic [2:0] MODE_XOF  = 3'd4;
    localparam logic [2:0] MODE_CXOF = 3'd5;

    // Core writeback register selects
    localparam logic [1:0] REG0_WRBACK_SEL = 2'd0;
    localparam logic [1:0] REG1_WRBACK_SEL = 2'd1;
    localparam logic [1:0] REG2_WRBACK_SEL = 2'd2;

    // Core state-word selects for the serial nonce load
    localparam logic [2:0] SHIFT_SEL_S3 = 3'd3;
    localparam logic [2:0] SHIFT_SEL_S4 = 3'd4;

    // Host register map, address bits [5:4]
    localparam logic [1:0] ADDR_KEY   = 2'd0;
    localparam logic [1:0] ADDR_TEXT  = 2'd1;
    localparam logic [1:0] ADDR_AD    = 2'd2;
    localparam logic [1:0] ADDR_NONCE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_S3 = 3'd1,
        ST_SHIFT_S4 = 3'd2,
        ST_START    = 3'd3,
        ST_RUN      = 3'd4
    } ctrl_state_t;

    // Byte idx (0 = LSB) of a 128-bit register
    function automatic logic [7:0] reg_byte(input logic [127:0] r, input logic [3:0] idx);
        return r[{idx, 3'b000} +: 8];
    endfunction

    // Modes the core actually implements
    function automatic logic mode_is_valid(input logic [2:0] m);
        return (m >= MODE_ENC) && (m <= MODE_CXOF);
    endfunction

    // AEAD modes need the nonce loaded into S_3/S_4 before start
    function automatic logic mode_uses_nonce(input logic [2:0] m);
        return (m == MODE_ENC) || (m == MODE_DEC);
    endfunction

endpackage

// File: rtl/ascon_nonce_shifter.sv
// Serializes the 128-bit nonce MSB first into core state words S_3
// (bits 127..64) then S_4 (bits 63..0), one bit per cycle for 128 cycles.
module ascon_nonce_shifter
    import ascon_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] nonce,
    output logic         shift_en,
    output logic [2:0]   sel,
    output logic         lsb,
    output logic         half,
    output logic         last
);

    logic [6:0] cnt_r;
    logic       active_r;
    logic [6:0] bit_idx_s;

    // Bit counter: 0..127 while active, stops after the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= 7'd0;
            active_r <= 1'b0;
        end else if (start) begin
            cnt_r    <= 7'd0;
            active_r <= 1'b1;
        end else if (active_r) begin
            cnt_r    <= cnt_r + 7'd1;
            active_r <= (cnt_r != 7'd127);
        end else begin
            cnt_r    <= cnt_r;
            active_r <= active_r;
        end
    end

    assign bit_idx_s = 7'd127 - cnt_r;

    // Serial outputs are forced to zero when not shifting
    always_comb begin
        shift_en = active_r;
        half     = active_r && (cnt_r == 7'd63);
        last     = active_r && (cnt_r == 7'd127);
        if (active_r) begin
            sel = cnt_r[6] ? SHIFT_SEL_S4 : SHIFT_SEL_S3;
            lsb = nonce[bit_idx_s];
        end else begin
            sel = 3'd0;
            lsb = 1'b0;
        end
    end

endmodule

// File: rtl/ascon_op_ctrl.sv
// Host-side controller/sequencer for the Ascon core: register file,
// nonce serialization, start pulse, writeback capture and status.
// Optional build macro ASCON_CTRL_KEY_ZEROIZE_EN: clears the key register
// on completion or abort.
module ascon_op_ctrl
    import ascon_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         host_wr_en,
    input  logic [5:0]   host_wr_addr,
    input  logic [7:0]   host_wr_data,
    input  logic [5:0]   host_rd_addr,
    output logic [7:0]   host_rd_data,
    input  logic         cmd_valid,
    input  logic [2:0]   cmd_mode,
    output logic         cmd_ready,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] reg0_128b,
    output logic [127:0] reg1_128b,
    output logic [127:0] reg2_128b,
    output logic [2:0]   operation_mode,
    output logic         operation_ready,
    output logic         state_shift_en,
    output logic [2:0]   state_shift_sel,
    output logic         state_shift_lsb,
    input  logic         reg_128b_wrback_en,
    input  logic [1:0]   reg_128b_wrback_sel,
    input  logic [127:0] reg_128b_wrback_val
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t     state_r, state_s;
    logic [TO_W-1:0] wd_r;
    logic [127:0]    key_r, text_r, ad_r, nonce_r;
    logic [2:0]      mode_r;
    logic            done_r, error_r, op_ready_r;

    logic cmd_accept_s, cmd_ok_s, shift_start_s;
    logic timeout_s, finish_s;
    logic shift_half_s, shift_last_s;

    assign cmd_accept_s = cmd_valid && (state_r == ST_IDLE);
    assign cmd_ok_s     = mode_is_valid(cmd_mode);
    assign timeout_s    = (state_r == ST_RUN) && (wd_r == WD_LAST);
    assign finish_s     = (state_r == ST_RUN) && reg_128b_wrback_en &&
                          (reg_128b_wrback_sel == REG2_WRBACK_SEL) && !timeout_s;

    ascon_nonce_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (shift_start_s),
        .nonce    (nonce_r),
        .shift_en (state_shift_en),
        .sel      (state_shift_sel),
        .lsb      (state_shift_lsb),
        .half     (shift_half_s),
        .last     (shift_last_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic and shifter launch
    always_comb begin
        state_s       = state_r;
        shift_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_accept_s && cmd_ok_s) begin
                    if (mode_uses_nonce(cmd_mode)) begin
                        state_s       = ST_SHIFT_S3;
                        shift_start_s = 1'b1;
                    end else begin
                        state_s = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT_S3: begin
                if (shift_half_s) state_s = ST_SHIFT_S4;
                else              state_s = ST_SHIFT_S3;
            end
            ST_SHIFT_S4: begin
                if (shift_last_s) state_s = ST_START;
                else              state_s = ST_SHIFT_S4;
            end
            ST_START: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (timeout_s || finish_s) state_s = ST_IDLE;
                else                       state_s = ST_RUN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Watchdog: counts RUN cycles from 0, cleared outside RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_r <= '0;
        end else if (state_r == ST_RUN) begin
            wd_r <= wd_r + TO_W'(1);
        end else begin
            wd_r <= '0;
        end
    end

    // Status outputs: start pulse, done pulse, sticky error, latched mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ready_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            mode_r     <= 3'd0;
        end else begin
            op_ready_r <= (state_s == ST_START);
            done_r     <= finish_s;
            if (cmd_accept_s) begin
                error_r <= !cmd_ok_s;
            end else if (timeout_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
            if (cmd_accept_s && cmd_ok_s) begin
                mode_r <= cmd_mode;
            end else if (state_s == ST_IDLE) begin
                mode_r <= 3'd0;
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Register file: host byte writes in IDLE, core writebacks override
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r   <= '0;
            text_r  <= '0;
            ad_r    <= '0;
            nonce_r <= '0;
        end else begin
            if (host_wr_en && (state_r == ST_IDLE)) begin
                case (host_wr_addr[5:4])
                    ADDR_KEY:   key_r[{host_wr_addr[3:0], 3'b000} +: 8]   <= host_wr_data;
                    ADDR_TEXT:  text_r[{host_wr_addr[3:0], 3'b000} +: 8]  <= host_wr_data;
                    ADDR_AD:    ad_r[{host_wr_addr[3:0], 3'b000} +: 8]    <= host_wr_data;
                    ADDR_NONCE: nonce_r[{host_wr_addr[3:0], 3'b000} +: 8] <= host_wr_data;
                    default:    key_r <= key_r;
                endcase
            end
            if (reg_128b_wrback_en) begin
                case (reg_128b_wrback_sel)
                    REG0_WRBACK_SEL: key_r  <= reg_128b_wrback_val;
                    REG1_WRBACK_SEL: text_r <= reg_128b_wrback_val;
                    REG2_WRBACK_SEL: ad_r   <= reg_128b_wrback_val;
                    default:         ad_r   <= ad_r;
                endcase
            end
`ifdef ASCON_CTRL_KEY_ZEROIZE_EN
            if (finish_s || timeout_s) begin
                key_r <= '0;
            end
`endif
        end
    end

    // Host read port, available in every state
    always_comb begin
        case (host_rd_addr[5:4])
            ADDR_KEY:   host_rd_data = reg_byte(key_r, host_rd_addr[3:0]);
            ADDR_TEXT:  host_rd_data = reg_byte(text_r, host_rd_addr[3:0]);
            ADDR_AD:    host_rd_data = reg_byte(ad_r, host_rd_addr[3:0]);
            ADDR_NONCE: host_rd_data = reg_byte(nonce_r, host_rd_addr[3:0]);
            default:    host_rd_data = 8'd0;
        endcase
    end

    assign cmd_ready       = (state_r == ST_IDLE);
    assign busy            = (state_r != ST_IDLE);
    assign done            = done_r;
    assign error           = error_r;
    assign operation_ready = op_ready_r;
    assign operation_mode  = mode_r;
    assign reg0_128b       = key_r;
    assign reg1_128b       = text_r;
    assign reg2_128b       = ad_r;

endmodule

// File: tb/tb_ascon_op_ctrl.sv
// Scoreboard testbench for ascon_op_ctrl: stimulus pushes expected events
// (shift bits, start pulse, done pulse, error changes) into queues and a
// negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_ascon_op_ctrl;

    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         host_wr_en = 1'b0;
    logic [5:0]   host_wr_addr = 6'd0;
    logic [7:0]   host_wr_data = 8'd0;
    logic [5:0]   host_rd_addr = 6'd0;
    logic [7:0]   host_rd_data;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_mode = 3'd0;
    logic         cmd_ready, busy, done, error;
    logic [127:0] reg0_128b, reg1_128b, reg2_128b;
    logic [2:0]   operation_mode;
    logic         operation_ready;
    logic         state_shift_en;
    logic [2:0]   state_shift_sel;
    logic         state_shift_lsb;
    logic         reg_128b_wrback_en = 1'b0;
    logic [1:0]   reg_128b_wrback_sel = 2'd0;
    logic [127:0] reg_128b_wrback_val = '0;

    ascon_op_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(10)) dut (
        .clk(clk), .rst(rst),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
        .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .error(error),
        .reg0_128b(reg0_128b), .reg1_128b(reg1_128b), .reg2_128b(reg2_128b),
        .operation_mode(operation_mode), .operation_ready(operation_ready),
        .state_shift_en(state_shift_en), .state_shift_sel(state_shift_sel),
        .state_shift_lsb(state_shift_lsb),
        .reg_128b_wrback_en(reg_128b_wrback_en), .reg_128b_wrback_sel(reg_128b_wrback_sel),
        .reg_128b_wrback_val(reg_128b_wrback_val)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic lsb; logic [2:0] sel; } shift_exp_t;
    typedef struct { int cyc; logic [2:0] mode; } start_exp_t;
    typedef struct { int cyc; logic val; } err_exp_t;

    shift_exp_t shift_q[$];
    start_exp_t start_q[$];
    int         done_q[$];
    err_exp_t   err_q[$];

    // Reference model: register contents and sticky error
    logic [127:0] m_reg [4];
    bit           m_err = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every DUT output event against the scoreboard
    shift_exp_t se;
    start_exp_t ste;
    err_exp_t   ee;
    int         de;
    logic       prev_err = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_err = 1'b0;
        end else begin
            if (state_shift_en) begin
                if (shift_q.size() == 0) chk("unexpected_shift", 1, 0);
                else begin
                    se = shift_q.pop_front();
                    chk("shift", {cyc, state_shift_lsb, state_shift_sel}, {se.cyc, se.lsb, se.sel});
                end
            end
            if (operation_ready) begin
                if (start_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    ste = start_q.pop_front();
                    chk("start", {cyc, operation_mode}, {ste.cyc, ste.mode});
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    de = done_q.pop_front();
                    chk("done_cycle", cyc, de);
                end
            end
            if (error !== prev_err) begin
                if (err_q.size() == 0) chk("unexpected_error_change", {cyc, error}, {cyc, prev_err});
                else begin
                    ee = err_q.pop_front();
                    chk("error_change", {cyc, error}, {ee.cyc, ee.val});
                end
            end
            prev_err = error;
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        host_wr_en         = 1'b0;
        reg_128b_wrback_en = 1'b0;
        cmd_valid          = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        m_reg[a[5:4]][a[3:0]*8 +: 8] = d;
        tick();
        host_wr_en = 1'b0;
    endtask

    task automatic load_reg(input int r, input logic [127:0] v);
        logic [1:0] rr;
        rr = r[1:0];
        for (int b = 0; b < 16; b++) host_write({rr, b[3:0]}, v[b*8 +: 8]);
    endtask

    task automatic check_regs();
        logic [127:0] rd;
        logic [1:0]   rr;
        for (int r = 0; r < 4; r++) begin
            rr = r[1:0];
            for (int b = 0; b < 16; b++) begin
                host_rd_addr = {rr, b[3:0]};
                #1;
                rd[b*8 +: 8] = host_rd_data;
            end
            chk($sformatf("reg%0d_readback", r), rd, m_reg[r]);
        end
        tick();
    endtask

    // Random activity for one cycle while the controller is busy
    task automatic side_traffic(input bit allow_sel2);
        int sel;
        host_wr_en   = ($urandom_range(0, 3) == 0);
        host_wr_addr = 6'($urandom);
        host_wr_data = 8'($urandom);
        cmd_valid    = ($urandom_range(0, 4) == 0);
        cmd_mode     = 3'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            sel = $urandom_range(0, 3);
            if (!allow_sel2 && sel == 2) sel = 3;
            reg_128b_wrback_en  = 1'b1;
            reg_128b_wrback_sel = sel[1:0];
            reg_128b_wrback_val = rand128();
            if (sel < 3) m_reg[sel] = reg_128b_wrback_val;
        end
    endtask

    // Expected consequences of a valid command accepted in cycle t
    task automatic expect_accept(input int t, input logic [2:0] mode, output int s);
        logic [2:0] sl;
        if (m_err) err_q.push_back('{t + 1, 1'b0});
        m_err = 1'b0;
        s = t + 1;
        if (mode == 3'd1 || mode == 3'd2) begin
            for (int i = 0; i < 128; i++) begin
                sl = (i < 64) ? 3'd3 : 3'd4;
                shift_q.push_back('{t + 1 + i, m_reg[3][127 - i], sl});
            end
            s = t + 129;
        end
        start_q.push_back('{s, mode});
    endtask

    task automatic do_cmd(input logic [2:0] mode, input bit do_wb, input int wb_k,
                          input logic [127:0] wb2_val, input bit poke, input bit quiet);
        int t, s;
        bit fin, last;
        t = cyc;
        cmd_valid = 1'b1; cmd_mode = mode;
        if (!(mode >= 3'd1 && mode <= 3'd5)) begin
            if (!m_err) err_q.push_back('{t + 1, 1'b1});
            m_err = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk("rejected_status", {busy, cmd_ready, operation_ready}, 3'b010);
            return;
        end
        expect_accept(t, mode, s);
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", {busy, cmd_ready}, 2'b10);
        while (cyc < s + 1) begin
            if (poke && cyc == t + 1) begin
                host_wr_en = 1'b1; host_wr_addr = 6'h10; host_wr_data = 8'hAA;
            end else if (!quiet) begin
                side_traffic(1'b1);
            end
            tick();
            clear_inputs();
        end
        for (int k = 0; k < TO; k++) begin
            fin  = do_wb && (k == wb_k);
            last = (k == TO - 1);
            if (fin) begin
                reg_128b_wrback_en  = 1'b1;
                reg_128b_wrback_sel = 2'd2;
                reg_128b_wrback_val = wb2_val;
                m_reg[2] = wb2_val;
                if (!last) done_q.push_back(cyc + 1);
            end else if (!last) begin
                if (!quiet) side_traffic(1'b0);
                else if (do_wb && k == wb_k - 1) begin
                    reg_128b_wrback_en  = 1'b1;
                    reg_128b_wrback_sel = 2'd1;
                    reg_128b_wrback_val = rand128();
                    m_reg[1] = reg_128b_wrback_val;
                end
            end
            if (fin || last) begin
                if (last) begin
                    if (!m_err) err_q.push_back('{cyc + 1, 1'b1});
                    m_err = 1'b1;
                end
`ifdef ASCON_CTRL_KEY_ZEROIZE_EN
                m_reg[0] = '0;
`endif
                tick();
                clear_inputs();
                break;
            end
            tick();
            clear_inputs();
        end
        chk("idle_after_op", {busy, cmd_ready}, 2'b01);
    endtask

    int t0, s0;

    initial begin
        for (int r = 0; r < 4; r++) m_reg[r] = '0;
        repeat (3) tick();
        chk("reset_outputs",
            {busy, cmd_ready, done, error, operation_ready, operation_mode,
             state_shift_en, state_shift_sel, state_shift_lsb},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0});
        rst = 1'b0;
        tick();
        check_regs();

        // Encrypt with known nonce; host poke of reg1 while busy is ignored
        load_reg(3, 128'h000102030405060708090A0B0C0D0E0F);
        load_reg(0, rand128());
        load_reg(1, rand128());
        load_reg(2, rand128());
        do_cmd(3'd1, 1'b1, 5, rand128(), 1'b1, 1'b1);
        check_regs();

        // Hash: writeback sel=1 then sel=2, done one cycle after sel=2
        do_cmd(3'd3, 1'b1, 4, 128'hDEAD0123456789ABCDEF00112233BEEF, 1'b0, 1'b1);
        check_regs();

        // Invalid mode sets error, a following valid encrypt clears it
        do_cmd(3'd7, 1'b0, 0, '0, 1'b0, 1'b1);
        tick();
        chk("error_after_reject", {error, busy}, 2'b10);
        do_cmd(3'd2, 1'b1, 2, rand128(), 1'b0, 1'b1);

        // Watchdog abort with no writeback
        do_cmd(3'd4, 1'b0, 0, '0, 1'b0, 1'b1);
        chk("error_after_timeout", {error, busy}, 2'b10);
        check_regs();

        // Same-cycle host write and core writeback to reg2 in IDLE: core wins
        host_wr_en = 1'b1; host_wr_addr = 6'h23; host_wr_data = 8'h55;
        reg_128b_wrback_en = 1'b1; reg_128b_wrback_sel = 2'd2;
        reg_128b_wrback_val = rand128();
        m_reg[2] = reg_128b_wrback_val;
        tick();
        clear_inputs();
        check_regs();

        // Asynchronous reset during the S_4 half of the nonce shift
        load_reg(3, rand128());
        t0 = cyc;
        cmd_valid = 1'b1; cmd_mode = 3'd2;
        expect_accept(t0, 3'd2, s0);
        tick();
        cmd_valid = 1'b0;
        while (cyc < t0 + 91) tick();
        rst = 1'b1;
        shift_q.delete(); start_q.delete(); done_q.delete(); err_q.delete();
        #1;
        chk("reset_mid_shift",
            {busy, cmd_ready, done, error, operation_ready, operation_mode,
             state_shift_en, state_shift_sel, state_shift_lsb},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0});
        for (int r = 0; r < 4; r++) m_reg[r] = '0;
        m_err = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_regs();

        // Randomized operations
        for (int it = 0; it < 30; it++) begin
            for (int w = 0; w < 4; w++) host_write(6'($urandom), 8'($urandom));
            do_cmd(3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0),
                   $urandom_range(0, TO + 2), rand128(), 1'b0, 1'b0);
            check_regs();
        end

        repeat (4) tick();
        chk("scoreboard_drained", shift_q.size() + start_q.size() + done_q.size() + err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
